// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl -- instruction fetch controller
//
// Issues one I-side bus read at a time at the fetch PC and writes the returned
// word(s) into the instruction FIFO. A flush redirects the fetch PC. Any fetch
// in flight when the flush arrives is still completed on the bus, but its data
// is discarded.
//
// Build option:
//   FETCH_DUAL_EN  when defined, an 8-byte aligned PC (pc[2]==0) writes both
//                  returned words and advances pc by 8. When undefined, only
//                  the first word is written and pc always advances by 4.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   fifo_full                     FIFO has fewer than 2 free slots (IDLE only)
//   flush, flush_pc               redirect request and target
//   inst_req, inst_addr           bus request valid / address
//   inst_addr_ok, inst_data_ok    bus address accept / read data return
//   inst_rdata1, inst_rdata2      words at inst_addr and inst_addr+4
//   write_en1/2, write_address1/2, write_data1/2   FIFO write ports
// -----------------------------------------------------------------------------

// One FIFO write lane: zeroes the address/data whenever the lane is not
// writing, so the FIFO-side buses are quiet outside write cycles.
module inst_fetch_ctrl_wr_lane (
  input  logic        en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] addr_o,
  output logic [31:0] data_o
);
  assign addr_o = en_i ? addr_i : 32'd0;
  assign data_o = en_i ? data_i : 32'd0;
endmodule

module inst_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_full,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata1,
  input  logic [31:0] inst_rdata2,
  output logic        write_en1,
  output logic        write_en2,
  output logic [31:0] write_address1,
  output logic [31:0] write_address2,
  output logic [31:0] write_data1,
  output logic [31:0] write_data2
);
  localparam int          NUM_LANES = 2;
  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT      = 3'd2,
    S_DROP_REQ  = 3'd3,
    S_DROP_WAIT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Address held on the bus; kept separate from pc so a flush while a request
  // is still unaccepted does not disturb inst_addr.
  logic [31:0] req_addr_q, req_addr_d;
  logic        wr_fire;
  logic        dual_sel;

  logic [NUM_LANES-1:0]       lane_en;
  logic [NUM_LANES-1:0][31:0] lane_addr, lane_data;
  logic [NUM_LANES-1:0][31:0] lane_addr_o, lane_data_o;

`ifdef FETCH_DUAL_EN
  // Second word is written only when both words lie in the same 8-byte block.
  assign dual_sel = ~pc_q[2];
`else
  assign dual_sel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_req   = 1'b0;
    wr_fire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // FIFO room is checked only here; a fetch in flight always fits.
        if (!fifo_full && !flush) begin
          state_d    = S_REQ;
          req_addr_d = pc_q;
        end
      end
      S_REQ: begin
        inst_req = 1'b1;
        if (inst_addr_ok) state_d = flush ? S_DROP_WAIT : S_WAIT;
        else if (flush)   state_d = S_DROP_REQ;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_IDLE;
          wr_fire = ~flush;
        end else if (flush) begin
          state_d = S_DROP_WAIT;
        end
      end
      S_DROP_REQ: begin
        // Request must stay up until accepted, even though its data is dead.
        inst_req = 1'b1;
        if (inst_addr_ok) state_d = S_DROP_WAIT;
      end
      S_DROP_WAIT: begin
        if (inst_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_fire) pc_d = pc_q + (dual_sel ? 32'd8 : 32'd4);
    // Redirect wins over the sequential advance.
    if (flush)   pc_d = flush_pc;
  end

  assign inst_addr = req_addr_q;

  assign lane_en   = {wr_fire & dual_sel, wr_fire};
  assign lane_addr = {pc_q + 32'd4, pc_q};
  assign lane_data = {inst_rdata2, inst_rdata1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    inst_fetch_ctrl_wr_lane u_lane (
      .en_i   (lane_en[g]),
      .addr_i (lane_addr[g]),
      .data_i (lane_data[g]),
      .addr_o (lane_addr_o[g]),
      .data_o (lane_data_o[g])
    );
  end

  assign write_en1      = lane_en[0];
  assign write_en2      = lane_en[1];
  assign write_address1 = lane_addr_o[0];
  assign write_address2 = lane_addr_o[1];
  assign write_data1    = lane_data_o[0];
  assign write_data2    = lane_data_o[1];

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl -- scoreboard bench for inst_fetch_ctrl.
// The driver applies inputs on the falling edge and pushes the expected
// per-cycle view (and any expected FIFO write) into queues. A monitor pops
// and compares shortly after each falling edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;
`ifdef FETCH_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_full = 1'b0, flush = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata1 = 32'd0, inst_rdata2 = 32'd0;
  logic        write_en1, write_en2;
  logic [31:0] write_address1, write_address2, write_data1, write_data2;

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .fifo_full(fifo_full), .flush(flush),
    .flush_pc(flush_pc), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata1(inst_rdata1), .inst_rdata2(inst_rdata2),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_address1(write_address1), .write_address2(write_address2),
    .write_data1(write_data1), .write_data2(write_data2)
  );

  always #5 clk = ~clk;

  typedef struct { logic req; logic [31:0] addr; logic wen; } ctl_t;
  typedef struct { logic en2; logic [31:0] a1, d1, a2, d2; } wr_t;
  ctl_t ctl_q[$];
  wr_t  wr_q[$];
  int checks = 0, errors = 0;

  // Transaction-level model: one fetch at a time, 0=no fetch, 1=request
  // waiting for acceptance, 2=waiting for data. 'doomed' marks a fetch whose
  // data must be thrown away because a flush arrived after it started.
  int          phase = 0;
  logic        doomed = 1'b0;
  logic [31:0] m_pc = RESET_PC, m_req_addr = RESET_PC;
  logic        rst_rel = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic f, input logic [31:0] fpc, input logic ff,
                      input logic aok, input logic dok);
    ctl_t c;
    wr_t  w;
    logic wr, en2;
    @(negedge clk);
    if (rst_rel) begin rst = 1'b1; rst_rel = 1'b0; end
    flush = f; flush_pc = fpc; fifo_full = ff;
    inst_addr_ok = aok; inst_data_ok = dok;
    inst_rdata1 = $urandom; inst_rdata2 = $urandom;
    wr  = rst && phase == 2 && dok && !doomed && !f;
    en2 = wr && DUAL && !m_pc[2];
    c.req = rst && phase == 1; c.addr = m_req_addr; c.wen = wr;
    ctl_q.push_back(c);
    if (wr) begin
      w.en2 = en2; w.a1 = m_pc; w.d1 = inst_rdata1;
      w.a2 = en2 ? m_pc + 32'd4 : 32'd0;
      w.d2 = en2 ? inst_rdata2 : 32'd0;
      wr_q.push_back(w);
    end
    if (rst) begin
      case (phase)
        0: if (!ff && !f) begin phase = 1; m_req_addr = m_pc; doomed = 1'b0; end
        1: begin if (f) doomed = 1'b1; if (aok) phase = 2; end
        default: if (dok) phase = 0; else if (f) doomed = 1'b1;
      endcase
      if (wr) m_pc = m_pc + (en2 ? 32'd8 : 32'd4);
      if (f)  m_pc = fpc;
    end
  endtask

  task automatic idle_step(); step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0); endtask

  // A normal fetch starting from no-fetch state with given latencies.
  task automatic run_fetch(input int alat, input int dlat);
    idle_step();
    repeat (alat) idle_step();
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    repeat (dlat) idle_step();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_quiet(input string name);
    chk({name, " inst_req"},  {31'd0, inst_req},  32'd0);
    chk({name, " write_en1"}, {31'd0, write_en1}, 32'd0);
    chk({name, " write_en2"}, {31'd0, write_en2}, 32'd0);
    chk({name, " wr_bus"}, write_address1 | write_address2 | write_data1 | write_data2, 32'd0);
  endtask

  // Monitor
  initial begin
    ctl_t c;
    wr_t  w;
    forever begin
      @(negedge clk);
      #1;
      if (ctl_q.size() != 0) begin
        c = ctl_q.pop_front();
        chk("inst_req", {31'd0, inst_req}, {31'd0, c.req});
        if (c.req) chk("inst_addr", inst_addr, c.addr);
        chk("write_en1", {31'd0, write_en1}, {31'd0, c.wen});
        if (write_en1) begin
          if (wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr %h expected no write", write_address1);
          end else begin
            w = wr_q.pop_front();
            chk("write_address1", write_address1, w.a1);
            chk("write_data1", write_data1, w.d1);
            chk("write_en2", {31'd0, write_en2}, {31'd0, w.en2});
            chk("write_address2", write_address2, w.a2);
            chk("write_data2", write_data2, w.d2);
          end
        end else begin
          chk("idle_write_bus", {31'd0, write_en2} | write_address1 | write_address2 |
              write_data1 | write_data2, 32'd0);
        end
      end
    end
  end

  // Driver
  initial begin
    logic f, aok, dok, ff;
    logic [31:0] fp;
    #1;
    check_quiet("reset");
    rst_rel = 1'b1;

    // Boot fetch: accept on the 2nd request cycle, data two cycles later.
    run_fetch(1, 1);
    run_fetch(0, 0);
    // Odd-word redirect, then a normal fetch.
    step(1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0);
    run_fetch(0, 1);
    run_fetch(1, 0);
    // Flush while waiting for data; dropped data; next fetch at target.
    idle_step(); step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h8000_1000, 1'b0, 1'b0, 1'b0);
    idle_step();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    run_fetch(0, 0);
    // Flush while request is unaccepted, addr_ok low 3 cycles.
    idle_step();
    step(1'b1, 32'h8000_2000, 1'b0, 1'b0, 1'b0);
    idle_step(); idle_step();
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h8000_3000, 1'b0, 1'b0, 1'b1);
    run_fetch(0, 0);
    // FIFO full held 5 cycles in no-fetch state.
    repeat (5) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    run_fetch(0, 0);
    // Wrap at top of address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
    run_fetch(0, 0);
    run_fetch(0, 0);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    run_fetch(0, 0);
    run_fetch(0, 0);
    // Reset asserted mid-fetch while data is being returned.
    idle_step(); step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #2;
    inst_data_ok = 1'b1;
    #1; rst = 1'b0;
    #1; check_quiet("async_reset");
    phase = 0; doomed = 1'b0; m_pc = RESET_PC; rst_rel = 1'b1;
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);   // stale response after reset
    run_fetch(0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      f  = ($urandom_range(9) == 0);
      case ($urandom_range(7))
        0:       fp = 32'hFFFF_FFF8;
        1:       fp = 32'hFFFF_FFFC;
        default: fp = $urandom & 32'hFFFF_FFFC;
      endcase
      ff  = ($urandom_range(4) == 0);
      aok = (phase == 1) && ($urandom_range(1) == 1);
      dok = (phase == 2) && ($urandom_range(2) == 0);
      step(f, fp, ff, aok, dok);
    end

    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #2;
    chk("pending_writes", ctl_q.size() + wr_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
